// File: rtl/sram_like_pkg.sv
// Shared widths, access-size encodings and the response record used by the
// SRAM-like responder and its response FIFO.
package sram_like_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    localparam logic [2:0] SZ_BYTE = 3'd0;
    localparam logic [2:0] SZ_HALF = 3'd1;
    localparam logic [2:0] SZ_WORD = 3'd2;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
    } resp_t;

endpackage

// File: rtl/resp_fifo.sv
// Synchronous FIFO of responses; pointers carry one extra wrap bit so that
// full and empty can be told apart when the index bits match.
module resp_fifo
    import sram_like_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic  clk,
    input  logic  resetn,
    input  logic  push,
    input  logic  pop,
    input  resp_t wdata,
    output logic  empty,
    output logic  full,
    output resp_t head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    resp_t       mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
        end
    end

    // Storage needs no reset: only entries behind the write pointer are read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/sram_like_responder.sv
// Responder end of the SRAM-like req/addr_ok/data_ok channel over a 1-cycle
// synchronous SRAM, with in-order responses, extra latency and stall knobs.
module sram_like_responder
    import sram_like_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned EXTRA_LAT = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req,
    input  logic              wr,
    input  logic [STRB_W-1:0] wstrb,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              addr_ok,
    output logic              data_ok,
    input  logic              req_stall,
    input  logic              resp_stall,
    output logic              ram_en,
    output logic [STRB_W-1:0] ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);
    localparam logic [CW-1:0] CntOne   = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] out_cnt_q;
    logic          hs;

    logic          cap_vld_q;
    logic          cap_wr_q;
    resp_t         cap_resp;

    logic          arr_vld;
    resp_t         arr_resp;

    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_push;
    logic          fifo_pop;
    logic          bypass;
    resp_t         fifo_head;

    logic          unused_size;

    // Size is carried by the protocol but the SRAM always transfers a word.
    assign unused_size = ^size ^ (size inside {SZ_BYTE, SZ_HALF, SZ_WORD});

    // Gated by resetn so nothing is accepted while reset is held.
    assign addr_ok = resetn & req & ~req_stall & (out_cnt_q < DepthCnt);
    assign hs      = req & addr_ok;

    assign ram_en    = hs;
    assign ram_wen   = (hs & wr) ? wstrb : '0;
    assign ram_addr  = addr;
    assign ram_wdata = wdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cap_vld_q <= 1'b0;
            cap_wr_q  <= 1'b0;
        end else begin
            cap_vld_q <= hs;
            cap_wr_q  <= hs & wr;
        end
    end

    // Writes respond with zero; idle slots stay zero so the pipe carries no junk.
    assign cap_resp.rdata = (cap_vld_q & ~cap_wr_q) ? ram_rdata : '0;

    if (EXTRA_LAT == 0) begin : g_no_pipe
        assign arr_vld  = cap_vld_q;
        assign arr_resp = cap_resp;
    end else begin : g_pipe
        logic [EXTRA_LAT-1:0] vld_q;
        resp_t                data_q [EXTRA_LAT];

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                vld_q <= '0;
                for (int i = 0; i < EXTRA_LAT; i++) begin
                    data_q[i] <= '0;
                end
            end else begin
                vld_q[0]  <= cap_vld_q;
                data_q[0] <= cap_resp;
                for (int i = 1; i < EXTRA_LAT; i++) begin
                    vld_q[i]  <= vld_q[i-1];
                    data_q[i] <= data_q[i-1];
                end
            end
        end

        assign arr_vld  = vld_q[EXTRA_LAT-1];
        assign arr_resp = data_q[EXTRA_LAT-1];
    end

    assign bypass    = arr_vld & fifo_empty & ~resp_stall;
    assign fifo_push = arr_vld & ~bypass & ~fifo_full;
    assign fifo_pop  = ~fifo_empty & ~resp_stall;
    assign data_ok   = (~fifo_empty | arr_vld) & ~resp_stall;

    always_comb begin
        rdata = '0;
        if (data_ok) begin
            rdata = fifo_empty ? arr_resp.rdata : fifo_head.rdata;
        end
    end

    resp_fifo #(
        .DEPTH(DEPTH)
    ) u_resp_fifo (
        .clk   (clk),
        .resetn(resetn),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (arr_resp),
        .empty (fifo_empty),
        .full  (fifo_full),
        .head  (fifo_head)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_cnt_q <= '0;
        end else begin
            unique case ({hs, data_ok})
                2'b10:   out_cnt_q <= out_cnt_q + CntOne;
                2'b01:   out_cnt_q <= out_cnt_q - CntOne;
                default: out_cnt_q <= out_cnt_q;
            endcase
        end
    end

endmodule
